hazard_forward_unit: RTL and testbench

- Hazard and forwarding controller for the 5-stage RV32I pipeline.
- Consumes per-instruction write-back descriptors (we_bypass, we_stall, ws) produced by the write-enable decoder in ID.
- Tracks them internally through EX/MEM/WB and drives the EX operand-forwarding mux selects, the load-use stall, and bubble insertion into EX.
- Sits beside the ID/EX pipeline register; fetch/decode and the EX operand muxes consume its outputs.

---
 rtl/hazard_forward_unit.sv | 124 ++++++++++++
 tb/tb_hazard_forward_unit.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/hazard_forward_unit.sv
// rtl/hazard_forward_unit.sv - load-use stall, EX bubble insertion and EX operand forwarding selects
// Define HAZARD_STATS_EN to add the stall_cnt / fwd_cnt hazard counters.
module hazard_forward_unit #(
  parameter int REG_AW = 5,
  parameter int SEL_W  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic              id_we_bypass,
  input  logic              id_we_stall,
  input  logic [REG_AW-1:0] id_ws,
  input  logic              flush,
  output logic              stall,
  output logic [SEL_W-1:0]  fwd_a_sel,
  output logic [SEL_W-1:0]  fwd_b_sel,
  output logic              ex_bubble
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       fwd_cnt
`endif
);

  localparam logic [SEL_W-1:0] SEL_RF  = SEL_W'(0);
  localparam logic [SEL_W-1:0] SEL_MEM = SEL_W'(1);
  localparam logic [SEL_W-1:0] SEL_WB  = SEL_W'(2);

  logic              ex_valid, ex_we_bypass, ex_we_stall, ex_use_rs1, ex_use_rs2, ex_bub;
  logic [REG_AW-1:0] ex_ws, ex_rs1, ex_rs2;
  // we_stall only matters while the producer sits in EX, so MEM/WB do not carry it.
  logic              mem_valid, mem_we_bypass;
  logic [REG_AW-1:0] mem_ws;
  logic              wb_valid, wb_we_bypass;
  logic [REG_AW-1:0] wb_ws;
  logic              hz_a, hz_b;

  always_comb begin
    hz_a  = id_valid && id_use_rs1 && (id_rs1 != '0) && ex_valid && ex_we_stall && (ex_ws == id_rs1);
    hz_b  = id_valid && id_use_rs2 && (id_rs2 != '0) && ex_valid && ex_we_stall && (ex_ws == id_rs2);
    stall = (hz_a || hz_b) && !flush;
  end

  function automatic logic [SEL_W-1:0] pick_fwd(input logic use_r, input logic [REG_AW-1:0] rs);
    logic hit_mem, hit_wb;
    hit_mem = use_r && (rs != '0) && mem_valid && mem_we_bypass && (mem_ws == rs);
    hit_wb  = use_r && (rs != '0) && wb_valid && wb_we_bypass && (wb_ws == rs);
    if (hit_mem)     pick_fwd = SEL_MEM;
    else if (hit_wb) pick_fwd = SEL_WB;
    else             pick_fwd = SEL_RF;
  endfunction

  always_comb begin
    fwd_a_sel = pick_fwd(ex_use_rs1, ex_rs1);
    fwd_b_sel = pick_fwd(ex_use_rs2, ex_rs2);
    ex_bubble = ex_bub;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid      <= 1'b0;
      ex_we_bypass  <= 1'b0;
      ex_we_stall   <= 1'b0;
      ex_use_rs1    <= 1'b0;
      ex_use_rs2    <= 1'b0;
      ex_bub        <= 1'b0;
      ex_ws         <= '0;
      ex_rs1        <= '0;
      ex_rs2        <= '0;
      mem_valid     <= 1'b0;
      mem_we_bypass <= 1'b0;
      mem_ws        <= '0;
      wb_valid      <= 1'b0;
      wb_we_bypass  <= 1'b0;
      wb_ws         <= '0;
    end else begin
      wb_valid      <= mem_valid;
      wb_we_bypass  <= mem_we_bypass;
      wb_ws         <= mem_ws;
      mem_valid     <= ex_valid;
      mem_we_bypass <= ex_we_bypass;
      mem_ws        <= ex_ws;
      if (flush || stall) begin
        // Bubble carries no operands or write, so it can neither forward nor be forwarded from.
        ex_valid     <= 1'b0;
        ex_we_bypass <= 1'b0;
        ex_we_stall  <= 1'b0;
        ex_use_rs1   <= 1'b0;
        ex_use_rs2   <= 1'b0;
        ex_bub       <= 1'b1;
        ex_ws        <= '0;
        ex_rs1       <= '0;
        ex_rs2       <= '0;
      end else begin
        ex_valid     <= id_valid;
        ex_we_bypass <= id_we_bypass;
        ex_we_stall  <= id_we_stall;
        ex_use_rs1   <= id_use_rs1;
        ex_use_rs2   <= id_use_rs2;
        ex_bub       <= 1'b0;
        ex_ws        <= id_ws;
        ex_rs1       <= id_rs1;
        ex_rs2       <= id_rs2;
      end
    end
  end

`ifdef HAZARD_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      fwd_cnt   <= '0;
    end else begin
      if (stall) stall_cnt <= stall_cnt + 32'd1;
      if ((fwd_a_sel != SEL_RF) || (fwd_b_sel != SEL_RF)) fwd_cnt <= fwd_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_forward_unit.sv
// tb/tb_hazard_forward_unit.sv - table-driven scoreboard bench for hazard_forward_unit
module tb_hazard_forward_unit;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       id_valid = 1'b0, id_use_rs1 = 1'b0, id_use_rs2 = 1'b0;
  logic       id_we_bypass = 1'b0, id_we_stall = 1'b0, flush = 1'b0;
  logic [4:0] id_rs1 = '0, id_rs2 = '0, id_ws = '0;
  logic       stall, ex_bubble;
  logic [1:0] fwd_a_sel, fwd_b_sel;
`ifdef HAZARD_STATS_EN
  logic [31:0] stall_cnt, fwd_cnt;
`endif

  always #5 clk = ~clk;

  hazard_forward_unit #(.REG_AW(5), .SEL_W(2)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_we_bypass(id_we_bypass),
    .id_we_stall(id_we_stall), .id_ws(id_ws), .flush(flush), .stall(stall),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .ex_bubble(ex_bubble)
`ifdef HAZARD_STATS_EN
    , .stall_cnt(stall_cnt), .fwd_cnt(fwd_cnt)
`endif
  );

  typedef struct packed {
    logic v; logic [4:0] rs1; logic u1; logic [4:0] rs2; logic u2;
    logic wb; logic wst; logic [4:0] ws; logic fl;
    logic es; logic [1:0] ea; logic [1:0] eb; logic ebub;
  } vec_t;

  typedef struct packed {
    logic [15:0] tag; logic es; logic [1:0] ea; logic [1:0] eb; logic ebub;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  vec_t tbl[$];
  int   errors = 0;
  int   checks = 0;

  function automatic vec_t mk(input logic v, input logic [4:0] rs1, input logic u1,
                              input logic [4:0] rs2, input logic u2, input logic wb,
                              input logic wst, input logic [4:0] ws, input logic fl,
                              input logic es, input logic [1:0] ea, input logic [1:0] eb,
                              input logic ebub);
    vec_t t;
    t.v = v; t.rs1 = rs1; t.u1 = u1; t.rs2 = rs2; t.u2 = u2; t.wb = wb; t.wst = wst;
    t.ws = ws; t.fl = fl; t.es = es; t.ea = ea; t.eb = eb; t.ebub = ebub;
    return t;
  endfunction

  function automatic vec_t idle(input logic es, input logic [1:0] ea, input logic [1:0] eb,
                                input logic ebub);
    return mk(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, es, ea, eb, ebub);
  endfunction

  task automatic apply(input vec_t t, input int tag);
    exp_t e;
    @(posedge clk); #1;
    id_valid = t.v; id_rs1 = t.rs1; id_use_rs1 = t.u1; id_rs2 = t.rs2; id_use_rs2 = t.u2;
    id_we_bypass = t.wb; id_we_stall = t.wst; id_ws = t.ws; flush = t.fl;
    e.tag = 16'(tag); e.es = t.es; e.ea = t.ea; e.eb = t.eb; e.ebub = t.ebub;
    exp_q.push_back(e);
  endtask

  task automatic chk(input int tag, input string what, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s vec%0d: got %0h want %0h", what, tag, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      cur = exp_q.pop_front();
      chk(int'(cur.tag), "stall",     32'(stall),     32'(cur.es));
      chk(int'(cur.tag), "fwd_a_sel", 32'(fwd_a_sel), 32'(cur.ea));
      chk(int'(cur.tag), "fwd_b_sel", 32'(fwd_b_sel), 32'(cur.eb));
      chk(int'(cur.tag), "ex_bubble", 32'(ex_bubble), 32'(cur.ebub));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic load_use(input int base);
    apply(mk(1, 5'd0, 0, 5'd0, 0, 1, 1, 5'd7, 0, 0, 2'b00, 2'b00, 0), base);
    apply(mk(1, 5'd1, 1, 5'd7, 1, 1, 0, 5'd9, 0, 1, 2'b00, 2'b00, 0), base + 1);
    apply(mk(1, 5'd1, 1, 5'd7, 1, 1, 0, 5'd9, 0, 0, 2'b00, 2'b00, 1), base + 2);
    apply(idle(0, 2'b00, 2'b10, 0), base + 3);
    apply(idle(0, 2'b00, 2'b00, 0), base + 4);
    apply(idle(0, 2'b00, 2'b00, 0), base + 5);
  endtask

  initial begin
    // Reset held two cycles with random ID inputs
    rst = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
      id_valid = 1'($urandom); id_rs1 = 5'($urandom); id_rs2 = 5'($urandom);
      id_use_rs1 = 1'($urandom); id_use_rs2 = 1'($urandom); id_we_bypass = 1'($urandom);
      id_we_stall = 1'($urandom); id_ws = 5'($urandom); flush = 1'($urandom);
    end
    apply(idle(0, 2'b00, 2'b00, 0), 0);
    rst = 1'b0;

    // ALU chain: add x5, sub rs1=x5, then rs2=x5
    tbl.push_back(mk(1, 5'd0, 0, 5'd0, 0, 1, 0, 5'd5, 0, 0, 2'b00, 2'b00, 0));
    tbl.push_back(mk(1, 5'd5, 1, 5'd0, 0, 1, 0, 5'd6, 0, 0, 2'b00, 2'b00, 0));
    tbl.push_back(mk(1, 5'd0, 0, 5'd5, 1, 1, 0, 5'd8, 0, 0, 2'b01, 2'b00, 0));
    tbl.push_back(idle(0, 2'b00, 2'b10, 0));
    tbl.push_back(idle(0, 2'b00, 2'b00, 0));
    tbl.push_back(idle(0, 2'b00, 2'b00, 0));
    // Two writers of x3 then a reader: MEM wins
    tbl.push_back(mk(1, 5'd0, 0, 5'd0, 0, 1, 0, 5'd3, 0, 0, 2'b00, 2'b00, 0));
    tbl.push_back(mk(1, 5'd0, 0, 5'd0, 0, 1, 0, 5'd3, 0, 0, 2'b00, 2'b00, 0));
    tbl.push_back(mk(1, 5'd3, 1, 5'd0, 0, 0, 0, 5'd0, 0, 0, 2'b00, 2'b00, 0));
    tbl.push_back(idle(0, 2'b01, 2'b00, 0));
    tbl.push_back(idle(0, 2'b00, 2'b00, 0));
    tbl.push_back(idle(0, 2'b00, 2'b00, 0));
    // x0 writer (load class) then x0 reader: no stall, no forward
    tbl.push_back(mk(1, 5'd0, 0, 5'd0, 0, 1, 1, 5'd0, 0, 0, 2'b00, 2'b00, 0));
    tbl.push_back(mk(1, 5'd0, 1, 5'd0, 1, 0, 0, 5'd0, 0, 0, 2'b00, 2'b00, 0));
    tbl.push_back(idle(0, 2'b00, 2'b00, 0));
    tbl.push_back(idle(0, 2'b00, 2'b00, 0));
    tbl.push_back(idle(0, 2'b00, 2'b00, 0));
    // Store-like slot (we_bypass=0) writing x10 never matches
    tbl.push_back(mk(1, 5'd0, 0, 5'd0, 0, 0, 0, 5'd10, 0, 0, 2'b00, 2'b00, 0));
    tbl.push_back(mk(1, 5'd10, 1, 5'd10, 1, 0, 0, 5'd0, 0, 0, 2'b00, 2'b00, 0));
    tbl.push_back(idle(0, 2'b00, 2'b00, 0));
    tbl.push_back(idle(0, 2'b00, 2'b00, 0));
    tbl.push_back(idle(0, 2'b00, 2'b00, 0));
    // Flush with a load-use hazard pending: flush wins
    tbl.push_back(mk(1, 5'd0, 0, 5'd0, 0, 1, 1, 5'd4, 0, 0, 2'b00, 2'b00, 0));
    tbl.push_back(mk(1, 5'd4, 1, 5'd0, 0, 1, 0, 5'd11, 1, 0, 2'b00, 2'b00, 0));
    tbl.push_back(idle(0, 2'b00, 2'b00, 1));
    tbl.push_back(idle(0, 2'b00, 2'b00, 0));
    tbl.push_back(idle(0, 2'b00, 2'b00, 0));
    tbl.push_back(idle(0, 2'b00, 2'b00, 0));

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], 100 + i);

    load_use(200);

    // Reset arriving while stall is asserted
    apply(mk(1, 5'd0, 0, 5'd0, 0, 1, 1, 5'd12, 0, 0, 2'b00, 2'b00, 0), 300);
    apply(mk(1, 5'd12, 1, 5'd0, 0, 0, 0, 5'd0, 0, 1, 2'b00, 2'b00, 0), 301);
    rst = 1'b1;
    apply(mk(1, 5'd12, 1, 5'd0, 0, 0, 0, 5'd0, 0, 0, 2'b00, 2'b00, 0), 302);
    rst = 1'b0;
    apply(idle(0, 2'b00, 2'b00, 0), 303);
    apply(idle(0, 2'b00, 2'b00, 0), 304);

`ifdef HAZARD_STATS_EN
    apply(idle(0, 2'b00, 2'b00, 0), 400);
    rst = 1'b1;
    apply(idle(0, 2'b00, 2'b00, 0), 401);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) load_use(410 + 10 * k);
    @(negedge clk);
    chk(500, "stall_cnt", stall_cnt, 32'd3);
    chk(501, "fwd_cnt", fwd_cnt, 32'd3);
`endif

    @(posedge clk);
    @(posedge clk);
    if (exp_q.size() != 0) begin
      errors++;
      checks++;
      $display("FAIL drain: %0d expected entries never compared", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
